// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address, and buffers fetched {pc, instr} pairs in a 2-entry FIFO that
// feeds decode. Redirects from execute flush the FIFO and reload the PC.
//
// Handshake (decode side): the head entry is offered while out_valid=1; it
// is consumed on a rising edge where out_valid=1 and out_ready=1. While
// out_valid=1 and out_ready=0 the offered head is held stable until it is
// consumed or a redirect flushes it. A pop on the same edge as a redirect
// still counts as consumed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        misalign_err,
  output logic [1:0]  dbg_count
);

  // Queue occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  q_state_e    state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Slot "head" is always the oldest entry; "tail" is only meaningful when full.
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic        err_q, err_d;

  logic        pop;
  logic        push;

  assign imem_addr    = pc_q;
  assign out_valid    = (state_q != Q_EMPTY);
  assign out_instr    = head_instr_q;
  assign out_pc       = head_pc_q;
  assign out_pc_plus4 = head_pc_q + 32'd4;
  assign misalign_err = err_q;
  assign dbg_count    = state_q;

  assign pop  = out_valid & out_ready;
  // A full queue can still accept a new word when the head leaves the same edge.
  assign push = fetch_en & ~redirect_valid & ((state_q != Q_FULL) | pop);

  // Next-state logic for occupancy, PC, queue slots and the sticky error flag.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;
    err_d        = err_q;

    if (redirect_valid) begin
      // Redirect wins over everything: flush and restart at the aligned target.
      state_d = Q_EMPTY;
      pc_d    = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        err_d = 1'b1;
      end
    end else begin
      if (push) begin
        pc_d = pc_q + PC_STEP;
      end
      case (state_q)
        Q_EMPTY: begin
          if (push) begin
            head_pc_d    = pc_q;
            head_instr_d = imem_instr;
            state_d      = Q_ONE;
          end
        end
        Q_ONE: begin
          if (push && !pop) begin
            tail_pc_d    = pc_q;
            tail_instr_d = imem_instr;
            state_d      = Q_FULL;
          end else if (push && pop) begin
            // The only entry leaves; the new word becomes the head directly.
            head_pc_d    = pc_q;
            head_instr_d = imem_instr;
          end else if (pop) begin
            state_d = Q_EMPTY;
          end
        end
        Q_FULL: begin
          if (pop) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            if (push) begin
              tail_pc_d    = pc_q;
              tail_instr_d = imem_instr;
            end else begin
              state_d = Q_ONE;
            end
          end
        end
        default: begin
          state_d = Q_EMPTY;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= Q_EMPTY;
      pc_q         <= RESET_PC;
      head_pc_q    <= 32'h0;
      head_instr_q <= 32'h0;
      tail_pc_q    <= 32'h0;
      tail_instr_q <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a per-cycle vector table covers streaming,
// backpressure, redirects, misalignment, wrap and fetch_en=0 draining; a
// hand-written sequence covers asynchronous reset between edges. A
// scoreboard queue holds the PCs decode is expected to accept, in order.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign_err;
  logic [1:0]  dbg_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ea;
    logic        ee;
    logic [1:0]  ec;
  } vec_t;

  vec_t vq[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .misalign_err   (misalign_err),
    .dbg_count      (dbg_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: fixed words at 0..12, address-derived elsewhere.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0:   mem_f = 32'h0053_6823;
      32'h4:   mem_f = 32'h0053_6833;
      32'h8:   mem_f = 32'h0053_6803;
      32'hC:   mem_f = 32'h0053_6863;
      default: mem_f = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_instr = mem_f(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rst, input logic fe, input logic rdy,
                              input logic rv, input logic [31:0] rpc, input logic ev,
                              input logic [31:0] epc, input logic [31:0] ea,
                              input logic ee, input logic [1:0] ec);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ea = ea; v.ee = ee; v.ec = ec;
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vq[i].rst) do_reset();
      fetch_en       = vq[i].fe;
      out_ready      = vq[i].rdy;
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      tick();
      chk($sformatf("row%0d valid", i), {31'h0, out_valid}, {31'h0, vq[i].ev});
      chk($sformatf("row%0d imem_addr", i), imem_addr, vq[i].ea);
      chk($sformatf("row%0d misalign", i), {31'h0, misalign_err}, {31'h0, vq[i].ee});
      chk($sformatf("row%0d count", i), {30'h0, dbg_count}, {30'h0, vq[i].ec});
      if (vq[i].ev) begin
        chk($sformatf("row%0d out_pc", i), out_pc, vq[i].epc);
        chk($sformatf("row%0d out_instr", i), out_instr, mem_f(vq[i].epc));
        chk($sformatf("row%0d out_pc_plus4", i), out_pc_plus4, vq[i].epc + 32'd4);
      end
    end
  endtask

  // Scoreboard: every accepted head must be the next expected PC.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb unexpected pop pc", out_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb pop pc", out_pc, e);
        chk("sb pop instr", out_instr, mem_f(e));
      end
    end
  end

  initial begin
    reset = 1'b0;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Stream (rows 0-4)
    vq.push_back(mk(1, 1, 1, 0, 32'h0, 1, 32'h0,  32'h4,  0, 2'd1));
    vq.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h4,  32'h8,  0, 2'd1));
    vq.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h8,  32'hC,  0, 2'd1));
    vq.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'hC,  32'h10, 0, 2'd1));
    vq.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h0,  32'h10, 0, 2'd0));
    // Backpressure (rows 5-13)
    vq.push_back(mk(1, 1, 0, 0, 32'h0, 1, 32'h0,  32'h4,  0, 2'd1));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h8, 0, 2'd2));
    vq.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h4,  32'hC,  0, 2'd2));
    vq.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h8,  32'h10, 0, 2'd2));
    vq.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h8,  32'h10, 0, 2'd2));
    // Redirect with full queue and concurrent pop (rows 14-16)
    vq.push_back(mk(0, 1, 1, 1, 32'h40, 0, 32'h0,  32'h40, 0, 2'd0));
    vq.push_back(mk(0, 1, 1, 0, 32'h0,  1, 32'h40, 32'h44, 0, 2'd1));
    vq.push_back(mk(0, 1, 1, 0, 32'h0,  1, 32'h44, 32'h48, 0, 2'd1));
    // Misaligned redirect, then back-to-back redirect (rows 17-19)
    vq.push_back(mk(0, 1, 1, 1, 32'h46, 0, 32'h0, 32'h44, 1, 2'd0));
    vq.push_back(mk(0, 1, 1, 1, 32'h80, 0, 32'h0, 32'h80, 1, 2'd0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,  0, 32'h0, 32'h80, 1, 2'd0));
    // Wrap (rows 20-23)
    vq.push_back(mk(0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'hFFFF_FFFC, 1, 2'd0));
    vq.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 1, 2'd1));
    vq.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h0,         32'h4, 1, 2'd1));
    vq.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h0,         32'h4, 1, 2'd0));
    // fetch_en=0 drain (rows 24-28)
    vq.push_back(mk(1, 1, 0, 0, 32'h0, 1, 32'h0, 32'h4, 0, 2'd1));
    vq.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h8, 0, 2'd2));
    vq.push_back(mk(0, 0, 1, 0, 32'h0, 1, 32'h4, 32'h8, 0, 2'd1));
    vq.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h8, 0, 2'd0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h8, 0, 2'd0));

    // Reset values while held in reset
    #1;
    chk("rst valid", {31'h0, out_valid}, 32'h0);
    chk("rst out_instr", out_instr, 32'h0);
    chk("rst out_pc", out_pc, 32'h0);
    chk("rst out_pc_plus4", out_pc_plus4, 32'h4);
    chk("rst misalign", {31'h0, misalign_err}, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0);

    exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4, 32'h8, 32'h40, 32'h44,
             32'hFFFF_FFFC, 32'h0};
    run_rows(0, 23);
    chk("sb drained after wrap", exp_q.size(), 0);

    // Build up state, then assert reset between edges
    fetch_en = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("async rst valid", {31'h0, out_valid}, 32'h0);
    chk("async rst out_instr", out_instr, 32'h0);
    chk("async rst out_pc", out_pc, 32'h0);
    chk("async rst out_pc_plus4", out_pc_plus4, 32'h4);
    chk("async rst misalign", {31'h0, misalign_err}, 32'h0);
    chk("async rst imem_addr", imem_addr, 32'h0);
    chk("async rst count", {30'h0, dbg_count}, 32'h0);

    exp_q = {32'h0, 32'h4};
    run_rows(24, 28);
    chk("sb drained after fetch_en=0", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
